// File: rtl/return_addr_stack_pkg.sv
// Frontend configuration and shared types for the return address stack.
package return_addr_stack_pkg;

    // Default number of RAS entries in the frontend configuration.
    localparam int unsigned RAS_DEPTH = 8;

    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

    // Top-of-stack pointer; wraps modulo RAS_DEPTH.
    typedef logic [RAS_PTR_W-1:0] ras_ptr_t;

    // Occupancy count, 0..RAS_DEPTH inclusive, hence one extra bit.
    typedef logic [RAS_PTR_W:0] ras_cnt_t;

endpackage

// File: rtl/ras_ptr_unit.sv
// Next-state logic for one RAS pointer pair (top-of-stack and occupancy).
// Used for both the speculative and the committed copy.
module ras_ptr_unit
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PtrW-1:0] tos_i,
    input  logic [PtrW:0]   cnt_i,
    output logic [PtrW-1:0] tos_nxt_o,
    output logic [PtrW:0]   cnt_nxt_o
);

    logic empty;
    logic full;

    assign empty = (cnt_i == '0);
    assign full  = (cnt_i == (PtrW+1)'(DEPTH));

    // Push advances (saturating count, oldest entry overwritten); pop retreats unless empty.
    // Push+pop on a non-empty stack replaces the top in place, so pointers hold.
    always_comb begin
        tos_nxt_o = tos_i;
        cnt_nxt_o = cnt_i;
        if (push_i && (!pop_i || empty)) begin
            tos_nxt_o = tos_i + PtrW'(1);
            if (!full) begin
                cnt_nxt_o = cnt_i + (PtrW+1)'(1);
            end
        end else if (pop_i && !push_i && !empty) begin
            tos_nxt_o = tos_i - PtrW'(1);
            cnt_nxt_o = cnt_i - (PtrW+1)'(1);
        end
    end

endmodule

// File: rtl/return_addr_stack.sv
// Return address stack: speculative push/pop from fetch, committed pointer copy
// from commit, flush restores the speculative pointers from the committed copy.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned XLEN  = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_addr_i,
    input  logic            pop_i,
    output logic [XLEN-1:0] top_o,
    output logic            top_valid_o,
    input  logic            com_push_i,
    input  logic            com_pop_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam bit DepthOk = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);

    // Return addresses are word aligned; the low two bits are not stored.
    logic [XLEN-3:0] mem_q [DEPTH];

    logic [PtrW-1:0] spec_tos_q, spec_tos_nxt;
    logic [PtrW:0]   spec_cnt_q, spec_cnt_nxt;
    logic [PtrW-1:0] com_tos_q, com_tos_nxt;
    logic [PtrW:0]   com_cnt_q, com_cnt_nxt;

    logic            mem_we;
    logic [PtrW-1:0] mem_waddr;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^push_addr_i[1:0];

    ras_ptr_unit #(
        .DEPTH (DEPTH)
    ) u_spec_ptr (
        .push_i    (push_i),
        .pop_i     (pop_i),
        .tos_i     (spec_tos_q),
        .cnt_i     (spec_cnt_q),
        .tos_nxt_o (spec_tos_nxt),
        .cnt_nxt_o (spec_cnt_nxt)
    );

    ras_ptr_unit #(
        .DEPTH (DEPTH)
    ) u_com_ptr (
        .push_i    (com_push_i),
        .pop_i     (com_pop_i),
        .tos_i     (com_tos_q),
        .cnt_i     (com_cnt_q),
        .tos_nxt_o (com_tos_nxt),
        .cnt_nxt_o (com_cnt_nxt)
    );

    // Write slot: replace the top on push+pop of a non-empty stack, else the slot above it.
    always_comb begin
        mem_we    = push_i && !flush_i;
        mem_waddr = spec_tos_q + PtrW'(1);
        if (pop_i && (spec_cnt_q != '0)) begin
            mem_waddr = spec_tos_q;
        end
    end

    // Pointer and entry state; flush takes the committed next state, fetch requests dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_tos_q <= '0;
            spec_cnt_q <= '0;
            com_tos_q  <= '0;
            com_cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            com_tos_q <= com_tos_nxt;
            com_cnt_q <= com_cnt_nxt;
            if (flush_i) begin
                spec_tos_q <= com_tos_nxt;
                spec_cnt_q <= com_cnt_nxt;
            end else begin
                spec_tos_q <= spec_tos_nxt;
                spec_cnt_q <= spec_cnt_nxt;
            end
            if (mem_we) begin
                mem_q[mem_waddr] <= push_addr_i[XLEN-1:2];
            end
        end
    end

    assign top_o       = {mem_q[spec_tos_q], 2'b00};
    assign top_valid_o = (spec_cnt_q != '0);

    a_depth_pow2: assert property (@(posedge clk_i) DepthOk);
    a_spec_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        spec_cnt_q <= (PtrW+1)'(DEPTH));
    a_com_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        com_cnt_q <= (PtrW+1)'(DEPTH));
    a_top_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        top_valid_o |-> !$isunknown(top_o));

endmodule
